// File: rtl/cl_align_pkg.sv
// Shared types and constants for the Camera Link 7:1 receive word aligner.
package cl_align_pkg;

    localparam int WORD_W  = 7;
    localparam int OFS_W   = 3;
    localparam int CNT_W   = 16;
    localparam int RETRY_W = 8;

    localparam logic [OFS_W-1:0]  OFS_MAX         = 3'd6;
    localparam logic [WORD_W-1:0] DEF_CLK_PATTERN = 7'b1100011;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HOLD,
        ST_SETTLE,
        ST_SEARCH,
        ST_LOCKED
    } align_state_e;

endpackage

// File: rtl/cl_gearbox7.sv
// 14-to-7 bit rotator: joins the current word with the previous one and picks a
// 7-bit window at the selected rotation, optionally registered.
module cl_gearbox7
    import cl_align_pkg::*;
#(
    parameter bit REG_OUT = 1'b1
)(
    input  logic              ICLK_buf,
    input  logic              global_rstn,
    input  logic [WORD_W-1:0] word,
    input  logic [OFS_W-1:0]  ofs,
    output logic [WORD_W-1:0] win
);

    logic [WORD_W-1:0]   prev;
    logic [2*WORD_W-1:0] cat;
    logic [WORD_W-1:0]   win_c;

    always_ff @(posedge ICLK_buf or negedge global_rstn) begin
        if (!global_rstn) prev <= '0;
        else              prev <= word;
    end

    // prev sits in the low half, so ofs=0 is the previous word unrotated
    assign cat   = {word, prev};
    assign win_c = WORD_W'(cat >> ofs);

    generate
        if (REG_OUT) begin : g_reg
            logic [WORD_W-1:0] win_q;
            always_ff @(posedge ICLK_buf or negedge global_rstn) begin
                if (!global_rstn) win_q <= '0;
                else              win_q <= win_c;
            end
            assign win = win_q;
        end else begin : g_comb
            assign win = win_c;
        end
    endgenerate

endmodule

// File: rtl/cl_rx_align_ctrl.sv
// ISERDES reset sequencer and clock-lane rotation search; once locked, every data
// lane is rotated by the same offset and presented with a valid flag.
module cl_rx_align_ctrl
    import cl_align_pkg::*;
#(
    parameter int                LANES          = 4,
    parameter int                SERDES_RST_CYC = 16,
    parameter int                SETTLE_CYC     = 8,
    parameter int                LOCK_CNT       = 16,
    parameter int                ERR_MAX        = 4,
    parameter logic [WORD_W-1:0] CLK_PATTERN    = DEF_CLK_PATTERN
)(
    input  logic                      RCLK,
    input  logic                      RST_N,
    input  logic                      EN,
    input  logic [WORD_W-1:0]         CLK_WORD,
    input  logic [WORD_W*LANES-1:0]   DATA_WORD,
    output logic                      SERDES_RST,
    output logic [OFS_W-1:0]          ALIGN_OFS,
    output logic                      LOCKED,
    output logic [WORD_W*LANES-1:0]   DATA_OUT,
    output logic                      DATA_VLD,
    output logic [RETRY_W-1:0]        RETRY_CNT,
    output logic                      LOCK_LOST
);

    localparam logic [CNT_W-1:0] HOLD_LD   = CNT_W'(SERDES_RST_CYC - 1);
    localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(SETTLE_CYC - 1);
    localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_CNT - 1);
    localparam logic [CNT_W-1:0] ERR_LAST  = CNT_W'(ERR_MAX - 1);

    align_state_e state, nxt_state;

    logic [CNT_W-1:0]   seq_cnt, nxt_seq;
    logic [CNT_W-1:0]   match_cnt, nxt_match;
    logic [CNT_W-1:0]   err_cnt, nxt_err;
    logic [OFS_W-1:0]   ofs_q, nxt_ofs;
    logic [RETRY_W-1:0] retry_q, nxt_retry;
    logic               nxt_lost;

    logic                           serdes_rst_q, locked_q, data_vld_q, lock_lost_q;
    logic [WORD_W-1:0]              clk_win;
    logic                           clk_match;
    logic [LANES-1:0][WORD_W-1:0]   data_win;

    cl_gearbox7 #(.REG_OUT(1'b0)) u_clk_gb (
        .ICLK_buf    (RCLK),
        .global_rstn (RST_N),
        .word        (CLK_WORD),
        .ofs         (ofs_q),
        .win         (clk_win)
    );

    generate
        for (genvar i = 0; i < LANES; i++) begin : g_lane
            cl_gearbox7 #(.REG_OUT(1'b1)) u_lane_gb (
                .ICLK_buf    (RCLK),
                .global_rstn (RST_N),
                .word        (DATA_WORD[i*WORD_W +: WORD_W]),
                .ofs         (ofs_q),
                .win         (data_win[i])
            );
        end
    endgenerate

    assign clk_match = (clk_win == CLK_PATTERN);

    always_comb begin
        nxt_state = state;
        nxt_seq   = seq_cnt;
        nxt_match = match_cnt;
        nxt_err   = err_cnt;
        nxt_ofs   = ofs_q;
        nxt_retry = retry_q;
        nxt_lost  = 1'b0;
        if (!EN) begin
            nxt_state = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    nxt_state = ST_HOLD;
                    nxt_seq   = HOLD_LD;
                end
                ST_HOLD: begin
                    if (seq_cnt == '0) begin
                        nxt_state = ST_SETTLE;
                        nxt_seq   = SETTLE_LD;
                    end else begin
                        nxt_seq = seq_cnt - 1'b1;
                    end
                end
                ST_SETTLE: begin
                    if (seq_cnt == '0) begin
                        nxt_state = ST_SEARCH;
                        nxt_ofs   = '0;
                        nxt_match = '0;
                    end else begin
                        nxt_seq = seq_cnt - 1'b1;
                    end
                end
                ST_SEARCH: begin
                    if (clk_match) begin
                        if (match_cnt == LOCK_LAST) begin
                            nxt_state = ST_LOCKED;
                            nxt_err   = '0;
                        end else begin
                            nxt_match = match_cnt + 1'b1;
                        end
                    end else begin
                        nxt_match = '0;
                        // all rotations exhausted: re-reset the ISERDES and start over
                        if (ofs_q == OFS_MAX) begin
                            nxt_ofs   = '0;
                            nxt_retry = (retry_q == '1) ? retry_q : retry_q + 1'b1;
                            nxt_state = ST_HOLD;
                            nxt_seq   = HOLD_LD;
                        end else begin
                            nxt_ofs = ofs_q + 1'b1;
                        end
                    end
                end
                ST_LOCKED: begin
                    if (clk_match) begin
                        nxt_err = '0;
                    end else if (err_cnt == ERR_LAST) begin
                        nxt_state = ST_SEARCH;
                        nxt_lost  = 1'b1;
                        nxt_ofs   = '0;
                        nxt_err   = '0;
                        nxt_match = '0;
                    end else begin
                        nxt_err = err_cnt + 1'b1;
                    end
                end
                default: nxt_state = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge RCLK or negedge RST_N) begin
        if (!RST_N) begin
            state     <= ST_IDLE;
            seq_cnt   <= '0;
            match_cnt <= '0;
            err_cnt   <= '0;
            ofs_q     <= '0;
            retry_q   <= '0;
        end else begin
            state     <= nxt_state;
            seq_cnt   <= nxt_seq;
            match_cnt <= nxt_match;
            err_cnt   <= nxt_err;
            ofs_q     <= nxt_ofs;
            retry_q   <= nxt_retry;
        end
    end

    // outputs registered off the next state so the ISERDES reset pin never glitches
    always_ff @(posedge RCLK or negedge RST_N) begin
        if (!RST_N) begin
            serdes_rst_q <= 1'b1;
            locked_q     <= 1'b0;
            data_vld_q   <= 1'b0;
            lock_lost_q  <= 1'b0;
        end else begin
            serdes_rst_q <= (nxt_state == ST_IDLE) || (nxt_state == ST_HOLD);
            locked_q     <= (nxt_state == ST_LOCKED);
            data_vld_q   <= (state == ST_LOCKED) && EN;
            lock_lost_q  <= nxt_lost;
        end
    end

    assign SERDES_RST = serdes_rst_q;
    assign ALIGN_OFS  = ofs_q;
    assign LOCKED     = locked_q;
    assign DATA_OUT   = data_win;
    assign DATA_VLD   = data_vld_q;
    assign RETRY_CNT  = retry_q;
    assign LOCK_LOST  = lock_lost_q;

endmodule

// File: tb/tb_cl_rx_align_ctrl.sv
// Directed bench for cl_rx_align_ctrl: reset, lock at several rotations, lock loss,
// EN drop, retry saturation and asynchronous reset while locked.
module tb_cl_rx_align_ctrl;

    localparam int         LANES = 4;
    localparam logic [6:0] PAT   = 7'b1100011;

    logic                  rclk = 1'b0;
    logic                  rst_n, en;
    logic [6:0]            clk_word;
    logic [7*LANES-1:0]    data_word;
    logic                  serdes_rst, locked, data_vld, lock_lost;
    logic [2:0]            align_ofs;
    logic [7*LANES-1:0]    data_out;
    logic [7:0]            retry_cnt;

    int                    n_chk = 0;
    int                    n_err = 0;
    int                    kd;
    logic [6:0]            d_cur [LANES];
    logic [6:0]            d_nxt [LANES];
    logic [7*LANES-1:0]    exp_data;

    always #5 rclk = ~rclk;

    cl_rx_align_ctrl #(
        .LANES(LANES), .SERDES_RST_CYC(16), .SETTLE_CYC(8),
        .LOCK_CNT(16), .ERR_MAX(4), .CLK_PATTERN(PAT)
    ) dut (
        .RCLK(rclk), .RST_N(rst_n), .EN(en),
        .CLK_WORD(clk_word), .DATA_WORD(data_word),
        .SERDES_RST(serdes_rst), .ALIGN_OFS(align_ofs), .LOCKED(locked),
        .DATA_OUT(data_out), .DATA_VLD(data_vld),
        .RETRY_CNT(retry_cnt), .LOCK_LOST(lock_lost)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [6:0] rotl7(input logic [6:0] w, input int k);
        logic [13:0] t;
        t = {w, w} << k;
        return t[13:7];
    endfunction

    // raw deserialized word whose window at rotation k reproduces the aligned word cur
    function automatic logic [6:0] raw7(input logic [6:0] nx, input logic [6:0] cur, input int k);
        logic [13:0] t;
        t = {nx, cur} << k;
        return t[13:7];
    endfunction

    task automatic drive();
        for (int i = 0; i < LANES; i++)
            data_word[7*i +: 7] = raw7(d_nxt[i], d_cur[i], kd);
    endtask

    task automatic tick();
        @(posedge rclk);
        #1;
        for (int i = 0; i < LANES; i++) begin
            exp_data[7*i +: 7] = d_cur[i];
            d_cur[i] = d_nxt[i];
            d_nxt[i] = 7'($urandom);
        end
        drive();
    endtask

    // from IDLE with EN high: returns the number of SERDES_RST-high samples and
    // leaves the bench on the first SEARCH cycle
    task automatic to_search(output int n);
        n = 0;
        for (int i = 0; i < 200; i++) begin
            tick();
            if (!serdes_rst) break;
            n++;
        end
        repeat (8) tick();
    endtask

    task automatic wait_lock(output int n);
        n = 0;
        while (!locked && n < 400) begin
            tick();
            n++;
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_serdes_rst"}, 32'(serdes_rst), 32'd1);
        chk({tag, "_ofs"},        32'(align_ofs),  32'd0);
        chk({tag, "_locked"},     32'(locked),     32'd0);
        chk({tag, "_data_out"},   32'(data_out),   32'd0);
        chk({tag, "_data_vld"},   32'(data_vld),   32'd0);
        chk({tag, "_retry"},      32'(retry_cnt),  32'd0);
        chk({tag, "_lock_lost"},  32'(lock_lost),  32'd0);
    endtask

    initial begin
        int n;
        logic [6:0] w3, bad3;
        rst_n    = 1'b0;
        en       = 1'b0;
        clk_word = '0;
        kd       = 3;
        exp_data = '0;
        for (int i = 0; i < LANES; i++) begin
            d_cur[i] = 7'($urandom);
            d_nxt[i] = 7'($urandom);
        end
        drive();
        repeat (3) @(posedge rclk);
        #1;
        chk_reset_vals("por");

        // clean lock at rotation 3
        w3       = rotl7(PAT, 3);
        bad3     = w3 ^ 7'b0000001;   // keeps the upper 4 bits so only whole words fail
        rst_n    = 1'b1;
        clk_word = w3;
        tick();
        tick();
        en = 1'b1;
        to_search(n);
        chk("hold_cyc", 32'(n), 32'd16);
        chk("search0_ofs", 32'(align_ofs), 32'd0);
        chk("search0_rst", 32'(serdes_rst), 32'd0);
        tick(); chk("ofs_step1", 32'(align_ofs), 32'd1);
        tick(); chk("ofs_step2", 32'(align_ofs), 32'd2);
        tick(); chk("ofs_step3", 32'(align_ofs), 32'd3);
        chk("pre_lock", 32'(locked), 32'd0);
        wait_lock(n);
        chk("lock_lat_r3", 32'(n), 32'd16);
        chk("vld_lag", 32'(data_vld), 32'd0);
        tick();
        chk("vld_r3", 32'(data_vld), 32'd1);
        for (int c = 0; c < 6; c++) begin
            tick();
            chk("data_r3", 32'(data_out), 32'(exp_data));
        end

        // three bad words are tolerated
        clk_word = bad3;
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("err3_locked", 32'(locked), 32'd1);
            chk("err3_lost", 32'(lock_lost), 32'd0);
        end
        clk_word = w3;
        tick(); chk("err3_recover", 32'(locked), 32'd1);
        tick(); chk("err3_hold", 32'(locked), 32'd1);

        // four bad words drop lock
        clk_word = bad3;
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("err4_pre", 32'(locked), 32'd1);
        end
        tick();
        chk("err4_locked", 32'(locked), 32'd0);
        chk("err4_lost", 32'(lock_lost), 32'd1);
        chk("err4_ofs", 32'(align_ofs), 32'd0);
        clk_word = rotl7(PAT, 5);
        kd = 5;
        drive();
        tick();
        chk("lost_pulse", 32'(lock_lost), 32'd0);
        wait_lock(n);
        chk("relock_lat_r5", 32'(n), 32'd20);
        chk("relock_ofs", 32'(align_ofs), 32'd5);
        tick();
        tick();
        chk("vld_r5", 32'(data_vld), 32'd1);
        chk("data_r5", 32'(data_out), 32'(exp_data));

        // EN drop while locked
        en = 1'b0;
        tick();
        chk("endrop_l_rst", 32'(serdes_rst), 32'd1);
        chk("endrop_l_locked", 32'(locked), 32'd0);
        chk("endrop_l_vld", 32'(data_vld), 32'd0);
        chk("endrop_l_ofs", 32'(align_ofs), 32'd5);
        chk("endrop_l_retry", 32'(retry_cnt), 32'd0);

        // rotation 0 locks after exactly LOCK_CNT cycles of SEARCH
        clk_word = PAT;
        kd = 0;
        drive();
        en = 1'b1;
        to_search(n);
        chk("hold_cyc_r0", 32'(n), 32'd16);
        wait_lock(n);
        chk("lock_lat_r0", 32'(n), 32'd16);
        chk("lock_ofs_r0", 32'(align_ofs), 32'd0);

        // EN drop mid-SEARCH
        en = 1'b0;
        tick();
        clk_word = '0;
        en = 1'b1;
        to_search(n);
        repeat (3) tick();
        chk("search_ofs3", 32'(align_ofs), 32'd3);
        en = 1'b0;
        tick();
        chk("endrop_s_rst", 32'(serdes_rst), 32'd1);
        chk("endrop_s_locked", 32'(locked), 32'd0);
        chk("endrop_s_vld", 32'(data_vld), 32'd0);
        chk("endrop_s_ofs", 32'(align_ofs), 32'd3);
        chk("endrop_s_retry", 32'(retry_cnt), 32'd0);

        // constant-zero clock lane: full search failure and retry
        en = 1'b1;
        to_search(n);
        repeat (6) tick();
        chk("fail_ofs6", 32'(align_ofs), 32'd6);
        chk("fail_rst_lo", 32'(serdes_rst), 32'd0);
        tick();
        chk("retry_rst_hi", 32'(serdes_rst), 32'd1);
        chk("retry_ofs", 32'(align_ofs), 32'd0);
        chk("retry_1", 32'(retry_cnt), 32'd1);
        n = 1;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (!serdes_rst) break;
            n++;
        end
        chk("retry_hold_cyc", 32'(n), 32'd16);
        while (retry_cnt != 8'd255 && n < 9000) begin
            tick();
            n++;
        end
        chk("retry_255_cyc", 32'(n), 32'd7874);
        repeat (100) tick();
        chk("retry_sat", 32'(retry_cnt), 32'd255);

        // asynchronous reset while locked
        clk_word = w3;
        kd = 3;
        drive();
        wait_lock(n);
        chk("final_lock", 32'(locked), 32'd1);
        tick();
        tick();
        chk("final_vld", 32'(data_vld), 32'd1);
        chk("final_ofs", 32'(align_ofs), 32'd3);
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset_vals("async");

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/cl_rx_align_ctrl.md
# cl_rx_align_ctrl

Word-alignment and reset sequencer for the Camera Link 7:1 receive path built on GTP_ISERDES instances in IDES7 mode. The block holds the ISERDES instances in reset, releases them, and then searches the 7 possible bit rotations of the deserialized clock-lane word for the Camera Link clock pattern. Once locked, it applies the same rotation to every data lane and presents aligned 7-bit words to the pixel unpacker. It runs entirely in the ISERDES parallel word clock domain.

## Interface
- LANES, 4: number of 7-bit data lanes.
- SERDES_RST_CYC, 16: RCLK cycles SERDES_RST is held high per reset pulse; ≥2.
- SETTLE_CYC, 8: RCLK cycles waited after SERDES_RST release before searching; ≥1.
- LOCK_CNT, 16: consecutive matching clock-lane words required to declare lock; ≥1.
- ERR_MAX, 4: consecutive mismatching words in LOCKED that drop lock; ≥1.
- CLK_PATTERN, 7'b1100011: expected aligned clock-lane word; bit 0 is the oldest bit.

Ports:
- RCLK  in  1  ISERDES parallel word clock; one new word per rising edge.
- RST_N  in  1  asynchronous, active-low reset.
- EN  in  1  alignment enable; level-sensitive.
- CLK_WORD  in  7  clock-lane ISERDES DO[7:1]; bit 0 (DO[1]) is the oldest bit.
- DATA_WORD  in  7*LANES  data-lane DO[7:1]; lane i occupies [7i+6:7i].
- SERDES_RST  out  1  active-high drive to the RST pin of every ISERDES instance.
- ALIGN_OFS  out  3  current rotation, 0..6.
- LOCKED  out  1  alignment achieved.
- DATA_OUT  out  7*LANES  aligned data words.
- DATA_VLD  out  1  DATA_OUT is valid.
- RETRY_CNT  out  8  saturating count of full-search failures.
- LOCK_LOST  out  1  one-cycle pulse when lock is dropped.

## Operation
- Reset values:
  - SERDES_RST=1.
  - ALIGN_OFS=0, LOCKED=0, DATA_OUT=0, DATA_VLD=0, RETRY_CNT=0, LOCK_LOST=0.
  - FSM in IDLE; all previous-word registers cleared to 0.
- Gearbox:
  - The block registers the previous word of every lane every cycle.
  - Window = {cur, prev}[ofs+6:ofs], with prev in bits [6:0]. ofs=0 selects the previous word unrotated.
  - Clock-lane compare: window == CLK_PATTERN, evaluated combinationally on the current CLK_WORD.
- FSM states:
  - IDLE: SERDES_RST=1. When EN=1, go to HOLD and load the counter.
  - HOLD: SERDES_RST=1 for SERDES_RST_CYC cycles, then go to SETTLE.
  - SETTLE: SERDES_RST=0. After SETTLE_CYC cycles, go to SEARCH with ofs=0 and match count 0.
  - SEARCH:
    - On a match, increment the match count. When it reaches LOCK_CNT, go to LOCKED.
    - On a mismatch, clear the match count and set ofs=ofs+1.
    - A mismatch at ofs=6 sets ofs=0, increments RETRY_CNT (saturating at 255) and returns to HOLD.
  - LOCKED:
    - ofs is frozen. A match clears the error count; a mismatch increments it.
    - When the error count reaches ERR_MAX: LOCK_LOST pulses, the FSM goes to SEARCH with ofs=0, and both counts clear.
- EN=0 in any state: next cycle the FSM is in IDLE with SERDES_RST=1, LOCKED=0, DATA_VLD=0. ALIGN_OFS and RETRY_CNT are held.
- LOCKED=1 exactly while the FSM is in LOCKED.
- Data path:
  - DATA_OUT is registered every cycle from each lane's window at the current ofs.
  - DATA_VLD is registered from (state==LOCKED), so it follows LOCKED by one cycle and aligns with DATA_OUT.
- Only one ALIGN_OFS step happens per cycle. A reset pulse through HOLD only happens after all 7 rotations have failed.

## Timing
- Latency from CLK_WORD/DATA_WORD to DATA_OUT is 1 RCLK cycle. The word presented at edge n, combined with the word from edge n-1, appears after edge n+1.
- From EN rising (sampled at edge 0), SERDES_RST stays high through SERDES_RST_CYC cycles of HOLD, then is low for SETTLE_CYC cycles before the first SEARCH compare.
- Each failing rotation costs 1 cycle.
- A perfect stream at rotation k locks k+LOCK_CNT cycles after SEARCH entry: k mismatch cycles, then LOCK_CNT matches.
- LOCK_LOST is high for exactly 1 cycle, coincident with the first cycle LOCKED=0.
- Asserting RST_N low forces all outputs to their reset values immediately, without waiting for a clock edge. Deassertion is synchronised externally.

## Structure
- Package cl_align_pkg holds:
  - State enum: IDLE, HOLD, SETTLE, SEARCH, LOCKED.
  - WORD_W=7.
  - Default CLK_PATTERN.
  - Counter width constants.
- Sub-module cl_gearbox7 contains the prev register and the 14-to-7 window mux. It has an optional output register, and one instance is used per lane plus one for the clock lane (clock-lane instance unregistered).
- The FSM and counters live in the top module.

## Test plan
- Reset: RST_N=0 while EN=1 and the FSM is LOCKED → asynchronously SERDES_RST=1, LOCKED=0, DATA_VLD=0, RETRY_CNT=0, ALIGN_OFS=0.
- Clean lock at rotation 3, with clock-lane stream CLK_PATTERN rotated by 3 and random data lanes rotated by 3:
  - SERDES_RST high exactly 16 cycles, then low.
  - After 8 cycles, ALIGN_OFS steps 0→1→2→3.
  - LOCKED after 16 matches.
  - DATA_OUT equals the injected words with 1-cycle latency and DATA_VLD=1.
- Rotation 0 stream: LOCKED is asserted exactly 16 cycles after SEARCH entry, with ALIGN_OFS=0.
- Constant 0 clock lane:
  - After offsets 0..6, RETRY_CNT=1 and SERDES_RST is reasserted for 16 cycles.
  - The cycle repeats indefinitely; RETRY_CNT saturates at 255.
- Lock loss, while locked at rotation 3:
  - 3 bad words then good → LOCKED stays 1.
  - 4 consecutive bad words → LOCK_LOST pulses once and LOCKED=0.
  - The stream then shifted to rotation 5 → re-lock with ALIGN_OFS=5.
- EN drop, once mid-SEARCH and once mid-LOCKED → next cycle the FSM is in IDLE with SERDES_RST=1, LOCKED=0 and DATA_VLD=0. RETRY_CNT and ALIGN_OFS are unchanged.
